switch_2x2_scheduler: RTL and testbench
=======================================

// Module: switch_2x2_scheduler
// PURPOSE
//  Packet-atomic scheduler between the two input FIFOs and two output FIFOs of the 2x2 Ethernet switch.
//  Reads the destination nibble of each head-of-line SOP word and pops the input FIFO.
//  Forwards each packet whole to the selected output FIFO; round-robin on output contention.
//  Drops packets with an unknown destination.
//  Replaces the free-running rd_en/wr_en glue between the FIFOs and the crossbar.
// PARAMETERS
//  DATA_W  32     data word width
//  ADDR_A  4'h1   DA[3:0] value routed to output A (index 0)
//  ADDR_B  4'h2   DA[3:0] value routed to output B (index 1)
//  CNT_W   16     width of statistics counters (saturating)
// PORTS
//  clk        in   1           single clock; all logic on posedge
//  reset      in   1           asynchronous, active-high reset
//  in_data    in   2xDATA_W    head word of input FIFO i (show-ahead)
//  in_sop     in   2           head word i is start of packet
//  in_eop     in   2           head word i is end of packet
//  in_empty   in   2           input FIFO i empty
//  in_rd      out  2           pop input FIFO i (comb)
//  out_data   out  2xDATA_W    word to output FIFO o (registered)
//  out_sop    out  2           SOP flag with out_data (registered)
//  out_eop    out  2           EOP flag with out_data (registered)
//  out_wr     out  2           write strobe to output FIFO o (registered)
//  out_afull  in   2           output FIFO o has <=1 free slot
//  pkt_cnt    out  2xCNT_W     packets fully forwarded to output o
//  drop_cnt   out  CNT_W       packets / stray words discarded
// BEHAVIOUR
//  Reset: all owners NONE, rr_last[o]=in1, in_rd=0, out_wr=0, out_data/sop/eop=0, counters=0.
//  Reset mid-packet: packet truncated; no EOP is synthesized.
//  Request: input i requests output o when it is unowned, !in_empty[i], in_sop[i], and in_data[i][3:0]==ADDR_o.
//  Per-output FSM, owner[o] in {NONE, IN0, IN1}:
//   NONE -> INx: registered grant at the edge after the request cycle.
//   Single requester wins. Two requesters: the one != rr_last[o] wins, then rr_last[o] <= winner.
//   INx -> NONE: at the edge where the EOP word of input x is popped.
//   Re-arbitration happens in the following cycle (one bubble per packet).
//  Outputs A and B may be owned concurrently by different inputs. An input is never owned by two outputs.
//  Pop rule: in_rd[i] = owned-by-o & !in_empty[i] & !out_afull[o].
//  Forwarding: out_wr[o]/out_data/out_sop/out_eop are registered copies of the popped word.
//   Latency: 1 cycle from in_rd to out_wr.
//   out_afull deasserted -> at least one pop per cycle; stalls hold ownership indefinitely.
//  Drop, per input, states IDLE/DROP:
//   Unowned head with SOP and DA not in {ADDR_A, ADDR_B}: enter DROP, pop every non-empty cycle until the EOP word is popped, then IDLE.
//   drop_cnt +1 per packet.
//   Unowned, non-empty head without SOP (stray word): pop the single word; drop_cnt +1.
//   SOP&EOP on one word: a 1-word packet, forwarded or dropped normally.
//  pkt_cnt[o] +1 when an EOP word is written to out_wr[o]. All counters saturate at all-ones.
//  in_empty rises mid-packet: no pop, ownership held; the output simply idles.
// STRUCTURE
//  Package switch_pkg: typedef enum owner_e {NONE, IN0, IN1}; typedef enum drop_st_e {IDLE, DROP};
//   localparam NPORT=2; address constants shared with switch_2x2.
//  Sub-module rr_arb2: 2-requester round-robin with last-grant register, instantiated once per output.
//  Top level holds owner regs, drop FSMs, output registers, counters.
// TESTING
//  1. In0 4-word pkt DA=1, outputs idle -> owner[0]=IN0 next cycle; out_wr[0] x4 starting 1 cycle after first in_rd; pkt_cnt[0]=1.
//  2. In0 and In1 SOP DA=2 same cycle after reset -> In0 forwarded first, one bubble, then In1; rr_last[1]=IN1.
//  3. In0 DA=1, In1 DA=2 same cycle -> both forwarded in parallel, no interleave; pkt_cnt={1,1}.
//  4. out_afull[0]=1 for 5 cycles mid-packet -> no pops, no out_wr[0], owner held; resumes with no word lost or duplicated.
//  5. In1 3-word pkt DA=4'hF, then stray non-SOP word -> all 4 words popped, no out_wr; drop_cnt=2.
//  6. reset asserted mid-packet -> in_rd/out_wr low immediately (async); counters and owners clear; the next SOP is forwarded normally.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and constants for the 2x2 switch scheduler.
// Address constants are common to switch_2x2 and its scheduler.
package switch_pkg;
  localparam int NPORT = 2;
  localparam logic [3:0] SW_ADDR_A = 4'h1;
  localparam logic [3:0] SW_ADDR_B = 4'h2;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IN0  = 2'd1,
    IN1  = 2'd2
  } owner_e;

  typedef enum logic {
    IDLE = 1'b0,
    DROP = 1'b1
  } drop_st_e;

  function automatic owner_e in2own(logic idx);
    return idx ? IN1 : IN0;
  endfunction
endpackage

// File: rtl/switch_2x2_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant register.
// Grants only while en_i is high; on a tie the non-last input wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) gnt_o = last_q ? 2'b01 : 2'b10;
      else        gnt_o = req_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_q <= 1'b1;
    else if (|gnt_o) last_q <= gnt_o[1];
  end
endmodule

// File: rtl/switch_2x2_scheduler.sv
// Packet-atomic scheduler between the 2x2 switch input and output FIFOs.
// Owns outputs per packet, forwards words one cycle late, drops bad traffic.
module switch_2x2_scheduler
  import switch_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter logic [3:0] ADDR_A = SW_ADDR_A,
  parameter logic [3:0] ADDR_B = SW_ADDR_B,
  parameter int         CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NPORT-1:0][DATA_W-1:0]  in_data,
  input  logic [NPORT-1:0]              in_sop,
  input  logic [NPORT-1:0]              in_eop,
  input  logic [NPORT-1:0]              in_empty,
  output logic [NPORT-1:0]              in_rd,
  output logic [NPORT-1:0][DATA_W-1:0]  out_data,
  output logic [NPORT-1:0]              out_sop,
  output logic [NPORT-1:0]              out_eop,
  output logic [NPORT-1:0]              out_wr,
  input  logic [NPORT-1:0]              out_afull,
  output logic [NPORT-1:0][CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]              drop_cnt
);
  owner_e   owner_q [NPORT];
  owner_e   owner_d [NPORT];
  drop_st_e drop_q  [NPORT];
  drop_st_e drop_d  [NPORT];

  logic [NPORT-1:0][NPORT-1:0] own_sel;
  logic [NPORT-1:0][NPORT-1:0] req;
  logic [NPORT-1:0][NPORT-1:0] fwd;
  logic [NPORT-1:0][NPORT-1:0] gnt;
  logic [NPORT-1:0] owned, free, bad, stray, dpop, src;
  logic [NPORT-1:0][3:0] da;

  logic [NPORT-1:0][DATA_W-1:0] out_data_q;
  logic [NPORT-1:0] out_sop_q, out_eop_q, out_wr_q;
  logic [NPORT-1:0][CNT_W-1:0] pkt_q;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]   drop_sum;
  logic [1:0]       n_drop;

  always_comb begin
    own_sel = '0;
    for (int o = 0; o < NPORT; o++)
      for (int i = 0; i < NPORT; i++)
        own_sel[o][i] = (owner_q[o] == in2own(1'(i)));
  end

  always_comb begin
    owned = '0;
    free  = '0;
    bad   = '0;
    stray = '0;
    dpop  = '0;
    da    = '0;
    for (int i = 0; i < NPORT; i++) begin
      da[i]    = in_data[i][3:0];
      owned[i] = own_sel[0][i] | own_sel[1][i];
      free[i]  = !owned[i] && (drop_q[i] == IDLE);
      bad[i]   = free[i] && !in_empty[i] && in_sop[i]
              && (da[i] != ADDR_A) && (da[i] != ADDR_B);
      stray[i] = free[i] && !in_empty[i] && !in_sop[i];
      dpop[i]  = bad[i] || stray[i]
              || (drop_q[i] == DROP && !in_empty[i]);
    end
  end

  always_comb begin
    req = '0;
    fwd = '0;
    src = '0;
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        req[o][i] = free[i] && !in_empty[i] && in_sop[i]
                 && (da[i] == ((o == 0) ? ADDR_A : ADDR_B));
        fwd[o][i] = own_sel[o][i] && !in_empty[i] && !out_afull[o];
      end
      src[o] = fwd[o][1];
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i (req[o]),
      .en_i  (owner_q[o] == NONE),
      .gnt_o (gnt[o])
    );
  end

  // Pops stop the instant reset rises, even for stray heads.
  always_comb begin
    in_rd = '0;
    for (int i = 0; i < NPORT; i++)
      in_rd[i] = !reset && (fwd[0][i] || fwd[1][i] || dpop[i]);
  end

  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      owner_d[o] = owner_q[o];
      unique case (owner_q[o])
        NONE: if (|gnt[o]) owner_d[o] = gnt[o][1] ? IN1 : IN0;
        IN0:  if (fwd[o][0] && in_eop[0]) owner_d[o] = NONE;
        IN1:  if (fwd[o][1] && in_eop[1]) owner_d[o] = NONE;
        default: owner_d[o] = NONE;
      endcase
    end
    for (int i = 0; i < NPORT; i++) begin
      drop_d[i] = drop_q[i];
      unique case (drop_q[i])
        IDLE: if (bad[i] && !in_eop[i]) drop_d[i] = DROP;
        DROP: if (!in_empty[i] && in_eop[i]) drop_d[i] = IDLE;
        default: drop_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    n_drop     = 2'(bad[0] | stray[0]) + 2'(bad[1] | stray[1]);
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NPORT; k++) begin
        owner_q[k] <= NONE;
        drop_q[k]  <= IDLE;
      end
      drop_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        owner_q[k] <= owner_d[k];
        drop_q[k]  <= drop_d[k];
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wr_q   <= '0;
      out_sop_q  <= '0;
      out_eop_q  <= '0;
      out_data_q <= '0;
      pkt_q      <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        out_wr_q[o] <= |fwd[o];
        if (|fwd[o]) begin
          out_data_q[o] <= in_data[src[o]];
          out_sop_q[o]  <= in_sop[src[o]];
          out_eop_q[o]  <= in_eop[src[o]];
          if (in_eop[src[o]] && !(&pkt_q[o]))
            pkt_q[o] <= pkt_q[o] + CNT_W'(1);
        end
      end
    end
  end

  assign out_wr   = out_wr_q;
  assign out_sop  = out_sop_q;
  assign out_eop  = out_eop_q;
  assign out_data = out_data_q;
  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_switch_2x2_scheduler.sv
// Randomized bench for switch_2x2_scheduler against a packet-level model.
// Input FIFOs are queues; every popped routed word must appear one cycle later.
module tb_switch_2x2_scheduler;
  import switch_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0][31:0]  in_data;
  logic [1:0]        in_sop, in_eop, in_empty, in_rd;
  logic [1:0][31:0]  out_data;
  logic [1:0]        out_sop, out_eop, out_wr, out_afull;
  logic [1:0][15:0]  pkt_cnt;
  logic [15:0]       drop_cnt;

  switch_2x2_scheduler dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_rd(in_rd),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_wr(out_wr), .out_afull(out_afull),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sop;
    logic        eop;
    logic [31:0] d;
    int          dst;
  } wrd_t;

  wrd_t q [2][$];
  wrd_t pend_w [2];
  logic [1:0] pend_v;
  int   cur_src [2];
  int   sop_log [2][$];
  int   exp_pkt [2];
  int   exp_drop;
  int   pid;
  logic [1:0] hide, af_force, last_rd;
  int   n_chk, n_pass;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic add_pkt(int i, logic [3:0] da, int len);
    wrd_t w;
    int dst;
    dst = (da == 4'h1) ? 0 : (da == 4'h2) ? 1 : 2;
    for (int k = 0; k < len; k++) begin
      w.sop = (k == 0);
      w.eop = (k == len - 1);
      w.d   = {1'(i), 7'(pid), 16'($urandom), 4'($urandom),
               (k == 0) ? da : 4'($urandom)};
      w.dst = dst;
      q[i].push_back(w);
    end
    if (dst < 2) exp_pkt[dst]++;
    else exp_drop++;
    pid++;
  endtask

  task automatic add_stray(int i);
    wrd_t w;
    w.sop = 1'b0;
    w.eop = 1'($urandom);
    w.d   = {1'(i), 31'($urandom)};
    w.dst = 2;
    q[i].push_back(w);
    exp_drop++;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      in_empty[i] = (q[i].size() == 0) || hide[i];
      if (q[i].size() > 0) begin
        in_data[i] = q[i][0].d;
        in_sop[i]  = q[i][0].sop;
        in_eop[i]  = q[i][0].eop;
      end else begin
        in_data[i] = '0;
        in_sop[i]  = 1'b0;
        in_eop[i]  = 1'b0;
      end
    end
  endtask

  task automatic cycle(bit rnd);
    logic [1:0] rd, nv;
    wrd_t nw [2];
    int s;
    @(negedge clk);
    for (int o = 0; o < 2; o++) begin
      check($sformatf("wr%0d", o), 64'(out_wr[o]), 64'(pend_v[o]));
      if (out_wr[o] && pend_v[o]) begin
        check($sformatf("word%0d", o),
              64'({out_sop[o], out_eop[o], out_data[o]}),
              64'({pend_w[o].sop, pend_w[o].eop, pend_w[o].d}));
        s = int'(out_data[o][31]);
        if (out_sop[o]) begin
          cur_src[o] = s;
          sop_log[o].push_back(s);
        end else begin
          check($sformatf("interleave%0d", o), 64'(s), 64'(cur_src[o]));
        end
      end
    end
    if (rnd) begin
      for (int o = 0; o < 2; o++) out_afull[o] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 2; i++) hide[i] = ($urandom_range(0, 9) == 0);
    end else begin
      out_afull = af_force;
      hide = 2'b00;
    end
    drive();
    #1;
    rd = in_rd;
    last_rd = rd;
    check("rd_empty", 64'(rd & in_empty), 64'(0));
    nv = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (rd[i] && q[i].size() > 0 && q[i][0].dst < 2) begin
        s = q[i][0].dst;
        check("afull_pop", 64'(out_afull[s]), 64'(0));
        check("collide", 64'(nv[s]), 64'(0));
        nv[s] = 1'b1;
        nw[s] = q[i][0];
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (rd[i] && q[i].size() > 0) void'(q[i].pop_front());
    pend_v = nv;
    pend_w = nw;
    drive();
  endtask

  task automatic drain(bit rnd);
    int k;
    k = 0;
    while ((q[0].size() + q[1].size() > 0 || pend_v != 0) && k < 3000) begin
      cycle(rnd);
      k++;
    end
    if (k >= 3000) check("drain_timeout", 64'(0), 64'(1));
    af_force = 2'b00;
    for (int j = 0; j < 3; j++) cycle(1'b0);
    check("pkt_cnt0", 64'(pkt_cnt[0]), 64'(exp_pkt[0]));
    check("pkt_cnt1", 64'(pkt_cnt[1]), 64'(exp_pkt[1]));
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; pid = 0; exp_drop = 0;
    exp_pkt = '{0, 0}; cur_src = '{0, 0};
    pend_v = 2'b00; hide = 2'b00; af_force = 2'b00;
    out_afull = 2'b00;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", 64'(in_rd), 64'(0));
    check("rst_wr", 64'(out_wr), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_pkt", 64'(pkt_cnt), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    add_pkt(0, 4'h1, 4);
    drive();
    cycle(1'b0);
    check("t1_req", 64'(last_rd), 64'(0));
    cycle(1'b0);
    check("t1_grant", 64'(last_rd), 64'(1));
    drain(1'b0);

    sop_log[1].delete();
    add_pkt(0, 4'h2, 3);
    add_pkt(0, 4'h2, 2);
    add_pkt(1, 4'h2, 3);
    drive();
    drain(1'b0);
    check("t2_n", 64'(sop_log[1].size()), 64'(3));
    if (sop_log[1].size() == 3) begin
      check("t2_first", 64'(sop_log[1][0]), 64'(0));
      check("t2_second", 64'(sop_log[1][1]), 64'(1));
      check("t2_third", 64'(sop_log[1][2]), 64'(0));
    end

    add_pkt(0, 4'h1, 4);
    add_pkt(1, 4'h2, 4);
    drive();
    cycle(1'b0);
    cycle(1'b0);
    check("t3_parallel", 64'(last_rd), 64'(3));
    drain(1'b0);

    add_pkt(0, 4'h1, 6);
    drive();
    repeat (3) cycle(1'b0);
    af_force = 2'b01;
    for (int j = 0; j < 5; j++) begin
      cycle(1'b0);
      check("t4_stall", 64'(last_rd), 64'(0));
    end
    af_force = 2'b00;
    drain(1'b0);

    add_pkt(1, 4'hF, 3);
    add_stray(1);
    drive();
    drain(1'b0);

    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 12; p++) begin
        int i, sel;
        logic [3:0] da;
        i = $urandom_range(0, 1);
        sel = $urandom_range(0, 5);
        da = (sel < 2) ? 4'h1 : (sel < 4) ? 4'h2 : (sel == 4) ? 4'hF : 4'h3;
        add_pkt(i, da, $urandom_range(1, 5));
        if ($urandom_range(0, 6) == 0) add_stray(i);
      end
      drive();
      drain(1'b1);
    end

    add_pkt(0, 4'h1, 6);
    drive();
    repeat (3) cycle(1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("t6_rd", 64'(in_rd), 64'(0));
    check("t6_wr", 64'(out_wr), 64'(0));
    check("t6_pkt", 64'(pkt_cnt), 64'(0));
    check("t6_drop", 64'(drop_cnt), 64'(0));
    pend_v = 2'b00;
    exp_pkt = '{0, 0};
    exp_drop = 0;
    for (int k = 0; k < q[0].size() && !q[0][k].sop; k++) begin
      q[0][k].dst = 2;
      exp_drop++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    add_pkt(0, 4'h1, 3);
    add_pkt(1, 4'h2, 2);
    drive();
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
